turf_tally: RTL and testbench

// Read-side counterpart of the pixel writer: after a round ends, scans the 160x120 playfield RAM
// (ram32768x3, address {x[7:0],y[6:0]}) and tallies the cells owned by each player.

---
 rtl/turf_tally.sv | 242 ++++++++++++++++++++++++
 tb/tb_turf_tally.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/turf_tally.sv
// -----------------------------------------------------------------------------
// turf_tally
//
// End-of-round territory counter. Once started, it walks the playfield RAM
// one address per cycle (y inner loop, x outer loop), counts the cells owned
// by each of the four players and then picks the largest count. The block only
// reads the RAM and has no write enable. The address is presented only while
// scanning. Outside a scan it holds its last value.
//
// Ports
//   CLOCK_50     in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   start        in   one-cycle scan request, honoured only when idle
//   ram_address  out  {x[7:0], y[6:0]} read address
//   ram_q        in   read data, valid RD_LATENCY cycles after ram_address
//   busy         out  high from the accepting edge through the done cycle
//   done         out  one-cycle pulse, counts and winner are valid
//   p1..p4_count out  cells coloured 001 / 010 / 100 / 110
//   winner       out  index of the largest count (0 = p1 .. 3 = p4)
//   tie          out  largest count is shared by two or more players
// -----------------------------------------------------------------------------
module turf_tally #(
  parameter int unsigned X_LAST     = 159,
  parameter int unsigned Y_LAST     = 119,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned COUNT_W    = 15
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start,
  output logic [14:0]        ram_address,
  input  logic [2:0]         ram_q,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] p1_count,
  output logic [COUNT_W-1:0] p2_count,
  output logic [COUNT_W-1:0] p3_count,
  output logic [COUNT_W-1:0] p4_count,
  output logic [1:0]         winner,
  output logic               tie
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StScan    = 3'd1;
  localparam logic [2:0] StDrain   = 3'd2;
  localparam logic [2:0] StCompare = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  localparam logic [7:0]         XLast     = 8'(X_LAST);
  localparam logic [6:0]         YLast     = 7'(Y_LAST);
  // Drain waits for the in-flight reads plus the cycle in which the last
  // sample is added, so the compare stage always sees final counts.
  localparam logic [1:0]         DrainLast = 2'(RD_LATENCY);
  localparam logic [COUNT_W-1:0] CountMax  = '1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]          state_q, state_d;
  logic [7:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic [1:0]          drain_q, drain_d;
  logic [1:0]          cmp_q, cmp_d;
  logic [COUNT_W-1:0]  max_q, max_d;
  logic [1:0]          win_q, win_d;
  logic                tie_q, tie_d;

  // vld_q[0] marks the address currently on ram_address. vld_q[RD_LATENCY]
  // marks the cycle in which ram_q carries that address's data.
  logic [RD_LATENCY:0] vld_q, vld_d;
  logic                issue;

  logic [COUNT_W-1:0]  cnt_q [4];
  logic [COUNT_W-1:0]  cnt_d [4];
  logic                clr_cnt;
  logic [3:0]          hit;

  // ---------------------------------------------------------------------------
  // Control FSM: scan addressing, drain, running-max compare
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    drain_d = drain_q;
    cmp_d   = cmp_q;
    max_d   = max_q;
    win_d   = win_q;
    tie_d   = tie_q;
    issue   = 1'b0;
    clr_cnt = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          // The first address goes out on the accepting edge itself.
          state_d = StScan;
          x_d     = 8'd0;
          y_d     = 7'd0;
          issue   = 1'b1;
          clr_cnt = 1'b1;
        end
      end

      StScan: begin
        if ((x_q == XLast) && (y_q == YLast)) begin
          state_d = StDrain;
          drain_d = 2'd0;
        end else begin
          issue = 1'b1;
          if (y_q == YLast) begin
            y_d = 7'd0;
            x_d = x_q + 8'd1;
          end else begin
            y_d = y_q + 7'd1;
          end
        end
      end

      StDrain: begin
        if (drain_q == DrainLast) begin
          // Seed the running maximum with player 1 on entry to compare.
          state_d = StCompare;
          max_d   = cnt_q[0];
          win_d   = 2'd0;
          tie_d   = 1'b0;
          cmp_d   = 2'd1;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end

      StCompare: begin
        // Strictly greater takes over; equal keeps the lower index but flags
        // the tie.
        if (cnt_q[cmp_q] > max_q) begin
          max_d = cnt_q[cmp_q];
          win_d = cmp_q;
          tie_d = 1'b0;
        end else if (cnt_q[cmp_q] == max_q) begin
          tie_d = 1'b1;
        end
        if (cmp_q == 2'd3) begin
          state_d = StDone;
        end else begin
          cmp_d = cmp_q + 2'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read pipeline and colour decode
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_d = {vld_q[RD_LATENCY-1:0], issue};
  end

  always_comb begin
    hit = 4'b0000;
    if (vld_q[RD_LATENCY]) begin
      case (ram_q)
        3'b001:  hit[0] = 1'b1;
        3'b010:  hit[1] = 1'b1;
        3'b100:  hit[2] = 1'b1;
        3'b110:  hit[3] = 1'b1;
        // 000 is empty, 111 is the timer bar, the rest are not player colours.
        default: hit = 4'b0000;
      endcase
    end
  end

  // Counters saturate at all-ones instead of wrapping.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_cnt) begin
        cnt_d[i] = '0;
      end else if (hit[i] && (cnt_q[i] != CountMax)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      x_q     <= 8'd0;
      y_q     <= 7'd0;
      drain_q <= 2'd0;
      cmp_q   <= 2'd0;
      max_q   <= '0;
      win_q   <= 2'd0;
      tie_q   <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      drain_q <= drain_d;
      cmp_q   <= cmp_d;
      max_q   <= max_d;
      win_q   <= win_d;
      tie_q   <= tie_d;
      vld_q   <= vld_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ram_address = {x_q, y_q};
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign p1_count    = cnt_q[0];
  assign p2_count    = cnt_q[1];
  assign p3_count    = cnt_q[2];
  assign p4_count    = cnt_q[3];
  assign winner      = win_q;
  assign tie         = tie_q;

endmodule

// File: tb/tb_turf_tally.sv
// -----------------------------------------------------------------------------
// tb_turf_tally
//
// Two instances run side by side. u_dut1 uses a 1-cycle RAM model and u_dut2
// uses a 2-cycle RAM model. Each instance has its own playfield memory.
// Expected counts, winner and tie are computed directly from the memory
// contents. Rows with y > 119 hold player-1 colour, so any stray read of those
// rows shows up in the counts.
// -----------------------------------------------------------------------------
module tb_turf_tally;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        start;
  logic [2:0]  mem1 [32768];
  logic [2:0]  mem2 [32768];
  logic [14:0] addr1, addr2;
  logic [2:0]  q1, q2, q2_s;
  logic        busy1, done1, tie1, busy2, done2, tie2;
  logic [1:0]  win1, win2;
  logic [14:0] p1a, p2a, p3a, p4a, p1b, p2b, p3b, p4b;
  logic [14:0] c1 [4];
  logic [14:0] c2 [4];

  always_comb begin
    c1[0] = p1a; c1[1] = p2a; c1[2] = p3a; c1[3] = p4a;
    c2[0] = p1b; c2[1] = p2b; c2[2] = p3b; c2[3] = p4b;
  end

  // RAM models: one and two register stages from address to data.
  always @(posedge clk) q1 <= mem1[addr1];
  always @(posedge clk) begin
    q2_s <= mem2[addr2];
    q2   <= q2_s;
  end

  turf_tally #(.RD_LATENCY(1)) u_dut1 (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .ram_address(addr1), .ram_q(q1),
    .busy(busy1), .done(done1), .p1_count(p1a), .p2_count(p2a), .p3_count(p3a),
    .p4_count(p4a), .winner(win1), .tie(tie1)
  );

  turf_tally #(.RD_LATENCY(2)) u_dut2 (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .ram_address(addr2), .ram_q(q2),
    .busy(busy2), .done(done2), .p1_count(p1b), .p2_count(p2b), .p3_count(p3b),
    .p4_count(p4b), .winner(win2), .tie(tie2)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int k1, k2, nd1, nd2, maxy;
  int ref_cnt [2][4];
  int ref_win [2];
  int ref_tie [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mem_wr(input int which, input logic [14:0] ad, input logic [2:0] v);
    if (which == 0) mem1[ad] = v;
    else            mem2[ad] = v;
  endtask

  function automatic logic [2:0] mem_rd(input int which, input logic [14:0] ad);
    return (which == 0) ? mem1[ad] : mem2[ad];
  endfunction

  // Fill the visible field with v. Rows with y > 119 get player-1 colour.
  task automatic fill(input int which, input logic [2:0] v);
    logic [14:0] ad;
    for (int a = 0; a < 32768; a++) begin
      ad = 15'(a);
      mem_wr(which, ad, (ad[6:0] > 7'd119) ? 3'b001 : v);
    end
  endtask

  task automatic fill_random(input int which);
    logic [14:0] ad;
    for (int a = 0; a < 32768; a++) begin
      ad = 15'(a);
      mem_wr(which, ad, (ad[6:0] > 7'd119) ? 3'b001 : 3'($urandom_range(0, 7)));
    end
  endtask

  // Paint n random distinct timer-bar cells with colour col.
  task automatic place(input int which, input logic [2:0] col, input int n);
    logic [14:0] ad;
    for (int i = 0; i < n; i++) begin
      do begin
        ad = {8'($urandom_range(0, 159)), 7'($urandom_range(0, 119))};
      end while (mem_rd(which, ad) != 3'b111);
      mem_wr(which, ad, col);
    end
  endtask

  // Reference: count colours over the 160x120 field and take the largest count.
  task automatic compute_ref(input int which);
    int c [4];
    int mx, n;
    for (int i = 0; i < 4; i++) c[i] = 0;
    for (int x = 0; x < 160; x++) begin
      for (int y = 0; y < 120; y++) begin
        case (mem_rd(which, {8'(x), 7'(y)}))
          3'b001:  if (c[0] < 32767) c[0]++;
          3'b010:  if (c[1] < 32767) c[1]++;
          3'b100:  if (c[2] < 32767) c[2]++;
          3'b110:  if (c[3] < 32767) c[3]++;
          default: ;
        endcase
      end
    end
    mx = 0;
    for (int i = 0; i < 4; i++) if (c[i] > mx) mx = c[i];
    n = 0;
    ref_win[which] = -1;
    for (int i = 0; i < 4; i++) begin
      if (c[i] == mx) begin
        n++;
        if (ref_win[which] < 0) ref_win[which] = i;
      end
      ref_cnt[which][i] = c[i];
    end
    ref_tie[which] = (n >= 2) ? 1 : 0;
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_l1_p%0d_count", tag, i + 1), c1[i], ref_cnt[0][i]);
      check($sformatf("%s_l2_p%0d_count", tag, i + 1), c2[i], ref_cnt[1][i]);
    end
    check($sformatf("%s_l1_winner", tag), win1, ref_win[0]);
    check($sformatf("%s_l1_tie", tag), tie1, ref_tie[0]);
    check($sformatf("%s_l2_winner", tag), win2, ref_win[1]);
    check($sformatf("%s_l2_tie", tag), tie2, ref_tie[1]);
  endtask

  // Pulse start, then observe at each falling edge. k counts edges after the
  // accepting edge. Optional disturbances: reset at rst_at, extra start at
  // restart_at, extra start in the L1 done cycle.
  task automatic run_scan(input string tag, input int rst_at, input int restart_at,
                          input bit poke_done, input bit chk_addr);
    logic [14:0] ea;
    int lim;
    k1 = -1; k2 = -1; nd1 = 0; nd2 = 0; maxy = 0;
    lim = (rst_at >= 0) ? rst_at + 200 : 19230;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_busy_l1_after_start"}, busy1, 1);
    check({tag, "_busy_l2_after_start"}, busy2, 1);
    for (int k = 0; k < lim; k++) begin
      if (done1) begin
        nd1++;
        if (k1 < 0) k1 = k;
        check({tag, "_busy_l1_in_done"}, busy1, 1);
      end
      if (done2) begin
        nd2++;
        if (k2 < 0) k2 = k;
      end
      if (busy1 && (int'(addr1[6:0]) > maxy)) maxy = int'(addr1[6:0]);
      if (chk_addr && k <= 125) begin
        ea = {8'(k / 120), 7'(k % 120)};
        check($sformatf("%s_addr_l1_k%0d", tag, k), addr1, ea);
        check($sformatf("%s_addr_l2_k%0d", tag, k), addr2, ea);
      end
      start = (k == restart_at) || (poke_done && done1);
      if (k == rst_at) begin
        resetn = 1'b0;
        #1;
        check({tag, "_rst_busy_l1"}, busy1, 0);
        check({tag, "_rst_busy_l2"}, busy2, 0);
        check({tag, "_rst_done_l1"}, done1, 0);
        check({tag, "_rst_addr_l1"}, addr1, 0);
        for (int i = 0; i < 4; i++) begin
          check($sformatf("%s_rst_l1_p%0d", tag, i + 1), c1[i], 0);
          check($sformatf("%s_rst_l2_p%0d", tag, i + 1), c2[i], 0);
        end
      end
      if (k == rst_at + 1) resetn = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_y_in_range"}, (maxy <= 119), 1);
    check({tag, "_busy_l1_end"}, busy1, 0);
    check({tag, "_busy_l2_end"}, busy2, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    fill(0, 3'b000);
    fill(1, 3'b010);
    repeat (3) @(negedge clk);
    check("reset_busy", busy1, 0);
    check("reset_done", done1, 0);
    check("reset_addr", addr1, 0);
    check("reset_p1", c1[0], 0);
    check("reset_p4", c1[3], 0);
    check("reset_winner", win1, 0);
    check("reset_tie", tie1, 0);
    check("reset_busy_l2", busy2, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Scan A: empty field on L1, all player 2 on L2, with address order checked.
    compute_ref(0);
    compute_ref(1);
    run_scan("a", -1, -1, 1'b0, 1'b1);
    check("a_done_time_l1", k1, 19205);
    check("a_done_time_l2", k2, 19206);
    check("a_done_pulses_l1", nd1, 1);
    check("a_done_pulses_l2", nd2, 1);
    check_results("a");

    // Scan B: random 100/250/250 placement in timer-bar fill on L1, and a
    // single p4 cell in the last corner on L2. Extra starts mid-scan and in
    // the done cycle must be ignored.
    fill(0, 3'b111);
    place(0, 3'b001, 100);
    place(0, 3'b100, 250);
    place(0, 3'b110, 250);
    fill(1, 3'b111);
    mem2[{8'd159, 7'd119}] = 3'b110;
    compute_ref(0);
    compute_ref(1);
    run_scan("b", -1, 500, 1'b1, 1'b0);
    check("b_done_time_l1", k1, 19205);
    check("b_done_time_l2", k2, 19206);
    check("b_done_pulses_l1", nd1, 1);
    check("b_done_pulses_l2", nd2, 1);
    check_results("b");

    // Scan C: reset mid-scan, so there is no done pulse and results are cleared.
    fill_random(0);
    fill_random(1);
    compute_ref(0);
    compute_ref(1);
    run_scan("c", 5000, -1, 1'b0, 1'b0);
    check("c_done_pulses_l1", nd1, 0);
    check("c_done_pulses_l2", nd2, 0);
    check("c_p2_after_reset", c1[1], 0);

    // Scan D: fresh start on the same random fields.
    run_scan("d", -1, -1, 1'b0, 1'b0);
    check("d_done_time_l1", k1, 19205);
    check("d_done_time_l2", k2, 19206);
    check("d_done_pulses_l1", nd1, 1);
    check_results("d");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
